wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline

---
 rtl/wb_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the in-order writeback stage
// and a multi-cycle execution unit. Multi-cycle results wait in a small
// in-order FIFO and drain whenever the writeback slot is idle. A head entry
// that is denied for too long forces a one-cycle pipeline freeze so it can
// write. Decode sources are compared against queued destinations so the
// hazard unit can hold decode.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  output logic            pend_hit,
  output logic            stall_o,
  output logic            RegWrite_o,
  output logic [4:0]      Rd_o,
  output logic [XLEN-1:0] WD_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  // FIFO storage; payload is never reset, only the occupancy bookkeeping is.
  logic [4:0]       rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Starvation tracking for the FIFO head.
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall_q;

  logic empty;
  logic full;
  logic accept;
  logic store;
  logic busy;
  logic grant_fifo;
  logic stall_set;

  // Saturating increment of the starvation counter; holds at MAX_WAIT.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    if (v == WAIT_W'(MAX_WAIT)) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Handshake and arbitration decisions from registered state and inputs.
  always_comb begin
    empty      = (count == '0);
    full       = (count == CNT_W'(DEPTH));
    mc_ready   = !rst && !full;
    accept     = mc_valid && mc_ready;
    // A result for x0 completes its handshake but is never queued.
    store      = accept && (mc_rd != 5'd0);
    busy       = RegWriteW && (RdW != 5'd0);
    // While stall_q is high the W instruction is frozen and re-presents next
    // cycle, so the FIFO head may take the port even if W wants it.
    grant_fifo = !empty && (!busy || stall_q);
    stall_set  = !grant_fifo && !empty && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    stall_o    = stall_q;
  end

  // Register-file write port mux; forced quiet while reset is asserted.
  always_comb begin
    RegWrite_o = 1'b0;
    Rd_o       = 5'd0;
    WD_o       = '0;
    if (!rst) begin
      if (grant_fifo) begin
        RegWrite_o = 1'b1;
        Rd_o       = rd_mem[rd_ptr];
        WD_o       = data_mem[rd_ptr];
      end else if (busy) begin
        RegWrite_o = 1'b1;
        Rd_o       = RdW;
        WD_o       = ResultW;
      end
    end
  end

  // Pending-write hit over every valid entry; x0 sources never hit.
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) begin
        if ((rs1_d != 5'd0) && (rd_mem[i] == rs1_d)) pend_hit = 1'b1;
        if ((rs2_d != 5'd0) && (rd_mem[i] == rs2_d)) pend_hit = 1'b1;
      end
    end
  end

  // FIFO payload write; no reset needed since vld gates every use.
  always_ff @(posedge clk) begin
    if (store) begin
      rd_mem[wr_ptr]   <= mc_rd;
      data_mem[wr_ptr] <= mc_data;
    end
  end

  // FIFO pointers, occupancy and per-entry valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      // Enqueue and dequeue never touch the same slot: enqueue needs a
      // non-full FIFO and dequeue a non-empty one, so the pointers differ.
      if (store) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (grant_fifo) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      case ({store, grant_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter and the one-cycle forced stall it triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (grant_fifo || empty) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= sat_inc(wait_cnt);
      end
      stall_q <= stall_set;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: a cycle-by-cycle vector table covering
// drain, x0 handling, pend_hit, starvation stall and FIFO-full backpressure,
// plus a hand-written sequence for reset in the middle of a forced stall.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic        pend_hit;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  Rd_o;
  logic [31:0] WD_o;

  int tests = 0;
  int fails = 0;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .pend_hit(pend_hit), .stall_o(stall_o),
    .RegWrite_o(RegWrite_o), .Rd_o(Rd_o), .WD_o(WD_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_ready;
    logic        e_hit;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic we, input logic [4:0] rdw, input logic [31:0] resw,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic e_ready, input logic e_hit, input logic e_stall,
    input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd);
    vec_t v;
    v.we = we; v.rdw = rdw; v.resw = resw;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e_ready = e_ready; v.e_hit = e_hit; v.e_stall = e_stall;
    v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rdw, input logic [31:0] resw,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    RegWriteW = we; RdW = rdw; ResultW = resw;
    mc_valid = mv; mc_rd = mrd; mc_data = mdat;
    rs1_d = rs1; rs2_d = rs2;
  endtask

  task automatic chk_all(input string tag, input logic ready, input logic hit,
                         input logic stall, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd);
    chk({tag, ".mc_ready"},   32'(mc_ready),   32'(ready));
    chk({tag, ".pend_hit"},   32'(pend_hit),   32'(hit));
    chk({tag, ".stall_o"},    32'(stall_o),    32'(stall));
    chk({tag, ".RegWrite_o"}, 32'(RegWrite_o), 32'(we));
    chk({tag, ".Rd_o"},       32'(Rd_o),       32'(rd));
    chk({tag, ".WD_o"},       WD_o,            wd);
  endtask

  initial begin
    int stall_seen;

    // Cycle-by-cycle vectors, starting from an empty FIFO after reset.
    //               we rdw resw          mv mrd mdat          rs1 rs2  rdy hit stl we rd  wd
    // Idle, then a single result drains on the next idle slot.
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  1, 0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 0, 0,  1, 0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        5, 0,  1, 1, 0, 1, 5,  32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        5, 0,  1, 0, 0, 0, 0,  32'h0));
    // x0 result handshakes but is dropped; W to x0 is not a write either.
    vecs.push_back(mk(0, 0, 32'h0,        1, 0,  32'h1234,     0, 0,  1, 0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 0, 32'hFFFF,     0, 0,  32'h0,        0, 0,  1, 0, 0, 0, 0,  32'h0));
    // pend_hit on rs1, none for x0 sources, hit on rs2 while it drains.
    vecs.push_back(mk(1, 9, 32'hAAAA,     1, 7,  32'h77,       0, 0,  1, 0, 0, 1, 9,  32'hAAAA));
    vecs.push_back(mk(1, 9, 32'hBBBB,     0, 0,  32'h0,        7, 0,  1, 1, 0, 1, 9,  32'hBBBB));
    vecs.push_back(mk(1, 9, 32'hBBBB,     0, 0,  32'h0,        0, 0,  1, 0, 0, 1, 9,  32'hBBBB));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 7,  1, 1, 0, 1, 7,  32'h77));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 7,  1, 0, 0, 0, 0,  32'h0));
    // W busy every cycle: head is starved, forced stall lets it write.
    vecs.push_back(mk(1, 3, 32'h33,       1, 12, 32'hC0C0,     0, 0,  1, 0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  32'h0,        0, 0,  1, 0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  32'h0,        0, 0,  1, 0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  32'h0,        0, 0,  1, 0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  32'h0,        0, 0,  1, 0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 12, 32'hC0C0));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  32'h0,        0, 0,  1, 0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  1, 0, 0, 0, 0,  32'h0));
    // Fill to DEPTH with W busy, third result is refused, then in-order drain.
    vecs.push_back(mk(1, 4, 32'h44,       1, 1,  32'h11,       0, 0,  1, 0, 0, 1, 4,  32'h44));
    vecs.push_back(mk(1, 4, 32'h44,       1, 2,  32'h22,       0, 0,  1, 0, 0, 1, 4,  32'h44));
    vecs.push_back(mk(1, 4, 32'h44,       1, 3,  32'h33,       0, 0,  0, 0, 0, 1, 4,  32'h44));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        2, 0,  0, 1, 0, 1, 1,  32'h11));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 0,  1, 0, 0, 1, 2,  32'h22));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        2, 0,  1, 0, 0, 0, 0,  32'h0));

    // Reset: outputs forced low even with live W and multi-cycle requests.
    rst = 1'b1;
    drive(1, 3, 32'h5555, 1, 6, 32'h6666, 3, 6);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].rdw, vecs[i].resw, vecs[i].mv, vecs[i].mrd,
            vecs[i].mdat, vecs[i].rs1, vecs[i].rs2);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_hit, vecs[i].e_stall,
              vecs[i].e_we, vecs[i].e_rd, vecs[i].e_wd);
    end

    // Two entries queued under a busy W until the forced stall fires,
    // then reset lands in the middle of the stall cycle.
    @(negedge clk);
    drive(1, 6, 32'h66, 1, 10, 32'hA, 0, 0);
    @(negedge clk);
    drive(1, 6, 32'h66, 1, 11, 32'hB, 0, 0);
    stall_seen = 99;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(1, 6, 32'h66, 0, 0, 0, 10, 0);
      #1;
      if (stall_o === 1'b1) begin
        stall_seen = k;
        break;
      end
    end
    chk("rst_mid.stall_cycle", 32'(stall_seen), 32'd4);
    chk("rst_mid.head_rd", 32'(Rd_o), 32'd10);
    chk("rst_mid.full", 32'(mc_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_all("rst_mid.async", 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 10, 11);
    #1;
    chk_all("rst_mid.after", 1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    drive(1, 8, 32'h88, 0, 0, 0, 11, 0);
    #1;
    chk_all("rst_mid.w_only", 1, 0, 0, 1, 8, 32'h88);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
